uart_hex_msg_gen: RTL and testbench

Upstream feeder for the PL-side AXI UART transmitter.
- Accepts a binary word on a valid/ready request port.
- Serialises it as ASCII: optional "0x" prefix, hex digits MSB-first, optional CR/LF.
- Emits the message one byte at a time on a valid/ready character stream that the AXI UART writer consumes.
- Gives PL logic a printf-like hex dump to the PS UART without software.

---
 rtl/uart_msg_pkg.sv | 20 ++
 rtl/hex_nibble_to_ascii.sv | 21 ++
 rtl/uart_hex_msg_gen.sv | 116 +++++++++++
 tb/tb_uart_hex_msg_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_pkg.sv
// rtl/uart_msg_pkg.sv - message states and ASCII constants for the hex message generator
package uart_msg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PFX0,
        PFX1,
        HEX,
        CR,
        LF
    } msg_state_t;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_X  = 8'h78;
    localparam logic [7:0] ASC_UA = 8'h41;
    localparam logic [7:0] ASC_LA = 8'h61;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// rtl/hex_nibble_to_ascii.sv - combinational 4-bit nibble to ASCII hex digit
module hex_nibble_to_ascii
    import uart_msg_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    localparam logic [7:0] ALPHA_BASE = UPPERCASE ? ASC_UA : ASC_LA;

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASC_0 + {4'h0, nibble};
        end else begin
            ascii = ALPHA_BASE + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_hex_msg_gen.sv
// rtl/uart_hex_msg_gen.sv - serialises a binary word as an ASCII hex message on a byte stream
module uart_hex_msg_gen
    import uart_msg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit PREFIX_EN  = 1'b1,
    parameter bit EOL_EN     = 1'b1,
    parameter bit UPPERCASE  = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [7:0]            char_data,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  msg_count
);

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

    msg_state_t            state, state_nxt;
    logic [DATA_WIDTH-1:0] shadow, shadow_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [3:0]            nibble_nxt;
    logic [7:0]            hex_char;
    logic [7:0]            char_nxt;
    logic                  msg_done;

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign char_valid = busy;

    // The character register is loaded from the *next* state so the byte is
    // already on char_data in the first cycle of every state.
    assign nibble_nxt = 4'(shadow_nxt >> {idx_nxt, 2'b00});

    hex_nibble_to_ascii #(
        .UPPERCASE(UPPERCASE)
    ) u_hex (
        .nibble(nibble_nxt),
        .ascii (hex_char)
    );

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        idx_nxt    = idx;
        msg_done   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    shadow_nxt = req_data;
                    idx_nxt    = IDX_TOP;
                    state_nxt  = PREFIX_EN ? PFX0 : HEX;
                end
            end
            PFX0: if (char_ready) state_nxt = PFX1;
            PFX1: if (char_ready) state_nxt = HEX;
            HEX: begin
                if (char_ready) begin
                    if (idx != '0) begin
                        idx_nxt = idx - 1'b1;
                    end else if (EOL_EN) begin
                        state_nxt = CR;
                    end else begin
                        state_nxt = IDLE;
                        msg_done  = 1'b1;
                    end
                end
            end
            CR: if (char_ready) state_nxt = LF;
            LF: begin
                if (char_ready) begin
                    state_nxt = IDLE;
                    msg_done  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        char_nxt = 8'h00;
        case (state_nxt)
            PFX0:    char_nxt = ASC_0;
            PFX1:    char_nxt = ASC_X;
            HEX:     char_nxt = hex_char;
            CR:      char_nxt = ASC_CR;
            LF:      char_nxt = ASC_LF;
            default: char_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            shadow    <= '0;
            idx       <= '0;
            char_data <= 8'h00;
            msg_count <= '0;
        end else begin
            state     <= state_nxt;
            shadow    <= shadow_nxt;
            idx       <= idx_nxt;
            char_data <= char_nxt;
            msg_count <= msg_count + CNT_WIDTH'(msg_done);
        end
    end

endmodule

// File: tb/tb_uart_hex_msg_gen.sv
// tb/tb_uart_hex_msg_gen.sv - self-checking bench for uart_hex_msg_gen
module tb_uart_hex_msg_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    logic [31:0] a_req_data;
    logic        a_req_valid, a_req_ready;
    logic [7:0]  a_char_data;
    logic        a_char_valid, a_char_ready, a_busy;
    logic [15:0] a_msg_count;

    logic [7:0]  b_req_data;
    logic        b_req_valid, b_req_ready;
    logic [7:0]  b_char_data;
    logic        b_char_valid, b_char_ready, b_busy;
    logic [1:0]  b_msg_count;

    int errors = 0;
    int checks = 0;
    int a_cnt_exp = 0;
    int b_cnt_exp = 0;

    uart_hex_msg_gen dut_a (
        .aclk(clk), .areset(areset),
        .req_data(a_req_data), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .char_data(a_char_data), .char_valid(a_char_valid), .char_ready(a_char_ready),
        .busy(a_busy), .msg_count(a_msg_count)
    );

    uart_hex_msg_gen #(
        .DATA_WIDTH(8), .PREFIX_EN(1'b0), .EOL_EN(1'b0), .UPPERCASE(1'b0), .CNT_WIDTH(2)
    ) dut_b (
        .aclk(clk), .areset(areset),
        .req_data(b_req_data), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .char_data(b_char_data), .char_valid(b_char_valid), .char_ready(b_char_ready),
        .busy(b_busy), .msg_count(b_msg_count)
    );

    // Reference message: prefix, every nibble MSB-first, then CR/LF.
    task automatic build_expected(input logic [63:0] w, input int dw, input bit pfx,
                                  input bit eol, input bit upper, output logic [7:0] q[$]);
        int n;
        q.delete();
        if (pfx) begin q.push_back(8'h30); q.push_back(8'h78); end
        for (int i = dw / 4 - 1; i >= 0; i--) begin
            n = int'((w >> (4 * i)) & 64'hF);
            if (n < 10) q.push_back(8'(48 + n));
            else        q.push_back(8'((upper ? 65 : 97) + n - 10));
        end
        if (eol) begin q.push_back(8'h0D); q.push_back(8'h0A); end
    endtask

    // mode 0: ready held, 1: ready toggles starting high, 2: random ready
    task automatic run_msg(input bit sel, input logic [63:0] w, input int mode, input int max_bytes,
                           output logic [7:0] got[$], output int wait_cyc, output int lat,
                           output int cycles, output int stab_err, output int ctl_err,
                           output bit timeout);
        logic [7:0] prev_d, cd;
        bit prev_stall, cv, rr, bz, rdy;
        got.delete();
        wait_cyc = 0; lat = 1; cycles = 0; stab_err = 0; ctl_err = 0; timeout = 0;
        prev_stall = 0; prev_d = 8'h00;
        if (sel) begin b_req_data = w[7:0]; b_req_valid = 1'b1; end
        else     begin a_req_data = w[31:0]; a_req_valid = 1'b1; end
        while (!(sel ? b_req_ready : a_req_ready) && wait_cyc < 100) begin
            @(posedge clk); #1; wait_cyc++;
        end
        if (wait_cyc >= 100) timeout = 1;
        @(posedge clk); #1;
        if (sel) begin b_req_valid = 1'b0; b_req_data = 8'($urandom); end
        else     begin a_req_valid = 1'b0; a_req_data = $urandom; end
        while (!(sel ? b_char_valid : a_char_valid) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        while (got.size() < max_bytes) begin
            if (cycles >= 400) begin timeout = 1; break; end
            cv = sel ? b_char_valid : a_char_valid;
            cd = sel ? b_char_data  : a_char_data;
            rr = sel ? b_req_ready  : a_req_ready;
            bz = sel ? b_busy       : a_busy;
            if (prev_stall && (!cv || cd !== prev_d)) stab_err++;
            if (!cv || rr || !bz) ctl_err++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (sel) b_char_ready = rdy; else a_char_ready = rdy;
            if (cv && rdy) got.push_back(cd);
            prev_stall = cv && !rdy;
            prev_d = cd;
            @(posedge clk); #1; cycles++;
        end
        a_char_ready = 1'b0;
        b_char_ready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        a_req_valid = 1'b1; a_req_data = 32'h1234_5678; a_char_ready = 1'b1;
        b_req_valid = 1'b1; b_req_data = 8'h55; b_char_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_char_valid !== 1'b0) begin errors++; $display("FAIL reset_char_valid got=%b exp=0", a_char_valid); end
        checks++; if (a_char_data !== 8'h00) begin errors++; $display("FAIL reset_char_data got=%h exp=00", a_char_data); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        checks++; if (a_msg_count !== 16'h0) begin errors++; $display("FAIL reset_msg_count got=%h exp=0", a_msg_count); end
        checks++; if (b_char_valid !== 1'b0 || b_msg_count !== 2'd0) begin errors++; $display("FAIL reset_b got_valid=%b got_cnt=%0d exp=0/0", b_char_valid, b_msg_count); end
        a_req_valid = 1'b0; b_req_valid = 1'b0; a_char_ready = 1'b0; b_char_ready = 1'b0;
        areset = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_req_ready !== 1'b1 || a_char_valid !== 1'b0) begin errors++; $display("FAIL reset_release_idle got_ready=%b got_valid=%b exp=1/0", a_req_ready, a_char_valid); end
    endtask

    task automatic test_deadbeef();
        logic [7:0] got[$], exp[$];
        int wc, lat, cyc, se, ce; bit to;
        build_expected(64'hDEADBEEF, 32, 1, 1, 1, exp);
        run_msg(0, 64'hDEADBEEF, 0, 12, got, wc, lat, cyc, se, ce, to);
        a_cnt_exp++;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL deadbeef_timeout got=%b exp=0", to); end
        checks++; if (lat != 1) begin errors++; $display("FAIL deadbeef_latency got=%0d exp=1", lat); end
        checks++; if (cyc != 12) begin errors++; $display("FAIL deadbeef_cycles got=%0d exp=12", cyc); end
        checks++; if (ce != 0) begin errors++; $display("FAIL deadbeef_ctl got=%0d exp=0", ce); end
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL deadbeef_len got=%0d exp=%0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL deadbeef_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
        checks++; if (a_msg_count !== 16'(a_cnt_exp)) begin errors++; $display("FAIL deadbeef_count got=%0d exp=%0d", a_msg_count, a_cnt_exp); end
        checks++; if (a_req_ready !== 1'b1 || a_char_valid !== 1'b0 || a_char_data !== 8'h00) begin errors++; $display("FAIL deadbeef_idle got_ready=%b got_valid=%b got_data=%h exp=1/0/00", a_req_ready, a_char_valid, a_char_data); end
    endtask

    task automatic test_zero_toggle();
        logic [7:0] got[$], exp[$];
        int wc, lat, cyc, se, ce; bit to;
        build_expected(64'h0, 32, 1, 1, 1, exp);
        run_msg(0, 64'h0, 1, 12, got, wc, lat, cyc, se, ce, to);
        a_cnt_exp++;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout got=%b exp=0", to); end
        checks++; if (se != 0) begin errors++; $display("FAIL zero_stable got=%0d exp=0", se); end
        checks++; if (ce != 0) begin errors++; $display("FAIL zero_ctl got=%0d exp=0", ce); end
        checks++; if (got.size() != 12) begin errors++; $display("FAIL zero_len got=%0d exp=12", got.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL zero_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
        checks++; if (a_msg_count !== 16'(a_cnt_exp)) begin errors++; $display("FAIL zero_count got=%0d exp=%0d", a_msg_count, a_cnt_exp); end
    endtask

    task automatic test_small_lower();
        logic [7:0] got[$], exp[$];
        int wc, lat, cyc, se, ce; bit to;
        build_expected(64'hAF, 8, 0, 0, 0, exp);
        run_msg(1, 64'hAF, 0, 2, got, wc, lat, cyc, se, ce, to);
        b_cnt_exp++;
        checks++; if (to !== 1'b0 || cyc != 2) begin errors++; $display("FAIL small_cycles got=%0d exp=2", cyc); end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL small_len got=%0d exp=2", got.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL small_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
        checks++; if (b_req_ready !== 1'b1 || b_char_valid !== 1'b0) begin errors++; $display("FAIL small_idle got_ready=%b got_valid=%b exp=1/0", b_req_ready, b_char_valid); end
        checks++; if (b_msg_count !== 2'(b_cnt_exp)) begin errors++; $display("FAIL small_count got=%0d exp=%0d", b_msg_count, 2'(b_cnt_exp)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$], exp[$];
        int wc, lat, cyc, se, ce; bit to;
        run_msg(0, 64'h12345678, 0, 12, got, wc, lat, cyc, se, ce, to);
        a_cnt_exp++;
        build_expected(64'h9ABCDEF0, 32, 1, 1, 1, exp);
        run_msg(0, 64'h9ABCDEF0, 0, 12, got, wc, lat, cyc, se, ce, to);
        a_cnt_exp++;
        checks++; if (wc != 0) begin errors++; $display("FAIL b2b_accept_wait got=%0d exp=0", wc); end
        checks++; if (lat != 1 || to !== 1'b0) begin errors++; $display("FAIL b2b_latency got=%0d exp=1", lat); end
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
        checks++; if (a_msg_count !== 16'(a_cnt_exp)) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", a_msg_count, a_cnt_exp); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got[$], exp[$];
        int wc, lat, cyc, se, ce, stray; bit to;
        build_expected(64'hCAFEF00D, 32, 1, 1, 1, exp);
        run_msg(0, 64'hCAFEF00D, 0, 4, got, wc, lat, cyc, se, ce, to);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL mid_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
        a_char_ready = 1'b1;
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        a_cnt_exp = 0; b_cnt_exp = 0;
        checks++; if (a_char_valid !== 1'b0 || a_char_data !== 8'h00) begin errors++; $display("FAIL mid_valid got=%b data=%h exp=0/00", a_char_valid, a_char_data); end
        checks++; if (a_req_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b busy=%b exp=1/0", a_req_ready, a_busy); end
        checks++; if (a_msg_count !== 16'h0) begin errors++; $display("FAIL mid_count got=%0d exp=0", a_msg_count); end
        stray = 0;
        repeat (4) begin @(posedge clk); #1; if (a_char_valid !== 1'b0) stray++; end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_stray got=%0d exp=0", stray); end
        a_char_ready = 1'b0;
        build_expected(64'h1, 32, 1, 1, 1, exp);
        run_msg(0, 64'h1, 0, 12, got, wc, lat, cyc, se, ce, to);
        a_cnt_exp++;
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL mid_new_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
        checks++; if (a_msg_count !== 16'(a_cnt_exp)) begin errors++; $display("FAIL mid_new_count got=%0d exp=%0d", a_msg_count, a_cnt_exp); end
    endtask

    task automatic test_random();
        logic [7:0] got[$], exp[$];
        logic [63:0] w;
        int wc, lat, cyc, se, ce; bit to, sel;
        for (int k = 0; k < 10; k++) begin
            sel = 1'($urandom_range(0, 1));
            if (sel) begin
                w = 64'($urandom_range(0, 255));
                build_expected(w, 8, 0, 0, 0, exp);
                run_msg(1, w, 2, exp.size(), got, wc, lat, cyc, se, ce, to);
                b_cnt_exp++;
            end else begin
                w = 64'($urandom);
                build_expected(w, 32, 1, 1, 1, exp);
                run_msg(0, w, 2, exp.size(), got, wc, lat, cyc, se, ce, to);
                a_cnt_exp++;
            end
            checks++; if (to !== 1'b0 || se != 0 || ce != 0) begin errors++; $display("FAIL rand%0d_proto to=%b stable=%0d ctl=%0d exp=0/0/0", k, to, se, ce); end
            foreach (exp[i]) begin
                checks++;
                if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL rand%0d_byte%0d w=%h got=%h exp=%h", k, i, w, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
            end
            checks++;
            if (a_msg_count !== 16'(a_cnt_exp) || b_msg_count !== 2'(b_cnt_exp)) begin
                errors++; $display("FAIL rand%0d_count got=%0d/%0d exp=%0d/%0d", k, a_msg_count, b_msg_count, 16'(a_cnt_exp), 2'(b_cnt_exp));
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [7:0] got[$];
        int wc, lat, cyc, se, ce; bit to;
        while (b_cnt_exp % 4 != 3) begin
            run_msg(1, 64'($urandom_range(0, 255)), 0, 2, got, wc, lat, cyc, se, ce, to);
            b_cnt_exp++;
        end
        checks++; if (b_msg_count !== 2'd3) begin errors++; $display("FAIL wrap_pre got=%0d exp=3", b_msg_count); end
        run_msg(1, 64'h5A, 0, 2, got, wc, lat, cyc, se, ce, to);
        b_cnt_exp++;
        checks++; if (b_msg_count !== 2'd0) begin errors++; $display("FAIL wrap_post got=%0d exp=0", b_msg_count); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        a_req_valid = 1'b0; a_req_data = '0; a_char_ready = 1'b0;
        b_req_valid = 1'b0; b_req_data = '0; b_char_ready = 1'b0;
        test_reset();
        test_deadbeef();
        test_zero_toggle();
        test_small_lower();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
